clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Consumes a divided clock (e.g. the divide-by-3, 50%-duty output) and verifies it against clock_in.
//  Samples the divided clock on both clock_in edges, giving half-cycle (HC) resolution.
//  Measures period and high time, reports each result, declares lock after repeated matches
//  and flags mismatches or a stalled clock. Sits directly downstream of the clock divider as a health monitor.
// PARAMETERS
//  CNT_W         8  width of HC counters and measurement outputs
//  EXP_PERIOD_HC 6  expected period in half-cycles (div-by-3 = 6)
//  EXP_HIGH_HC   3  expected high time in half-cycles (50% duty = 3)
//  LOCK_COUNT    4  consecutive matching periods required to assert locked
// PORTS
//  clock_in    in   1      reference clock; all outputs on posedge
//  reset_n     in   1      asynchronous, active-low reset
//  div_clk_in  in   1      divided clock under test
//  enable      in   1      1 = monitor active; 0 = return to IDLE
//  err_clear   in   1      one-cycle pulse, clears sticky error
//  period_hc   out  CNT_W  last measured period, half-cycles
//  high_hc     out  CNT_W  last measured high time, half-cycles
//  meas_valid  out  1      one-cycle pulse: period_hc/high_hc updated
//  locked      out  1      LOCK_COUNT consecutive matches seen
//  error       out  1      sticky: mismatch or timeout occurred
// BEHAVIOUR
//  Reset: every output 0. FSM = IDLE. All counters 0. Sample flops 0.
//  Sampling:
//   - s_n captures div_clk_in at negedge; s_p captures it at posedge.
//   - Each posedge processes the ordered pair h0 = s_n (previous negedge), then h1 = div_clk_in.
//   - prev = last processed sample. Every transition is seen a uniform 1 HC late, so measurements are unaffected.
//  Counting (SEEK/MEASURE):
//   - hc_cnt counts half-samples since the last rising edge: +1 or +2 per cycle, saturating at 2^CNT_W-1.
//   - Rising edge = 0->1 between prev/h0 or h0/h1. It closes the period (count up to and including the HC before the edge) and restarts hc_cnt at the edge.
//   - Falling edge = 1->0; latches hi_cnt = HCs high since the rising edge.
//   - Rise and fall may both occur in one cycle (1-HC pulse): process them in h0,h1 order.
//   - Two rises in one cycle are impossible.
//  FSM:
//   - IDLE: enable=0. Counters cleared. locked=0. period_hc/high_hc/error hold. enable=1 -> SEEK.
//   - SEEK: wait for the first rising edge; discard the partial period. Rise -> MEASURE.
//   - MEASURE: on each rising edge, on the next posedge:
//     - period_hc<=period, high_hc<=hi_cnt, meas_valid=1 for 1 cycle.
//     - Match (both equal expected): match_cnt++ (saturate). locked=1 when match_cnt reaches LOCK_COUNT, i.e. on the same meas_valid.
//     - Mismatch: match_cnt=0, locked=0, error=1.
//     - Timeout (hc_cnt saturates): error=1, locked=0, match_cnt=0, no meas_valid, -> SEEK.
//   - enable=0 in any state -> IDLE next cycle. A measurement in flight is dropped.
//  error: set has priority over err_clear in the same cycle. err_clear in IDLE allowed.
//  reset_n mid-operation: immediate asynchronous return to reset values, including the negedge flop.
//  Width: counters CNT_W bits, no wrap, saturation only.
// STRUCTURE
//  Package clk_mon_pkg: FSM state enum (IDLE, SEEK, MEASURE) and the default expected-value constants.
//  Sub-module hc_sampler: negedge/posedge capture flops plus h0/h1/prev alignment, and rise/fall flags per slot.
//  Top: counters, FSM, compare/lock logic.
// TESTING
//  1 div_clk_in from a divide-by-3, 50% divider, enable=1:
//    - meas_valid every 3 clocks; period_hc=6, high_hc=3.
//    - locked=1 on the 4th meas_valid; error=0.
//  2 divide-by-3 without the negedge stage (high 2 cycles):
//    - period_hc=6, high_hc=4, error=1, locked never set.
//  3 div_clk_in stuck 0 after lock:
//    - error=1, locked=0 once hc_cnt hits 255 (about 128 clocks); FSM in SEEK.
//    - Restored divider relocks after 4 matching periods.
//  4 1-HC high pulse every 6 HC:
//    - high_hc=1, period_hc=6, error=1.
//    - Check same-cycle rise+fall handling.
//  5 err_clear pulsed in the same cycle as a mismatch -> error stays 1. err_clear alone next cycle -> error=0.
//  6 Collisions:
//    - enable dropped mid-period -> IDLE, locked=0, no meas_valid. Re-enable -> SEEK.
//    - reset_n asserted mid-MEASURE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// Shared types and default expectations for the divided-clock health monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        MEASURE
    } mon_state_e;

    localparam int DEF_CNT_W         = 8;
    localparam int DEF_EXP_PERIOD_HC = 6;
    localparam int DEF_EXP_HIGH_HC   = 3;
    localparam int DEF_LOCK_COUNT    = 4;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the divided clock source/consumer and the monitor.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             div_clk_in;
    logic             enable;
    logic             err_clear;
    logic [CNT_W-1:0] period_hc;
    logic [CNT_W-1:0] high_hc;
    logic             meas_valid;
    logic             locked;
    logic             error;

    modport master (
        output div_clk_in, enable, err_clear,
        input  period_hc, high_hc, meas_valid, locked, error
    );

    modport slave (
        input  div_clk_in, enable, err_clear,
        output period_hc, high_hc, meas_valid, locked, error
    );
endinterface

// File: rtl/clk_div_monitor_hc_sampler.sv
// Samples the divided clock on both reference edges and flags rise/fall per half-cycle slot.
module hc_sampler (
    input  logic clock_in,
    input  logic reset_n,
    input  logic div_i,
    output logic rise0_o,
    output logic rise1_o,
    output logic fall0_o,
    output logic fall1_o
);
    logic s_n_q;
    logic s_p_q;

    always_ff @(negedge clock_in or negedge reset_n) begin
        if (!reset_n) s_n_q <= 1'b0;
        else          s_n_q <= div_i;
    end

    // s_p_q is the last processed sample (prev) for the next posedge.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) s_p_q <= 1'b0;
        else          s_p_q <= div_i;
    end

    assign rise0_o = ~s_p_q & s_n_q;
    assign fall0_o =  s_p_q & ~s_n_q;
    assign rise1_o = ~s_n_q & div_i;
    assign fall1_o =  s_n_q & ~div_i;
endmodule

// File: rtl/clk_div_monitor.sv
// Half-cycle period/high-time monitor for a divided clock: measures, locks and flags errors.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int EXP_PERIOD_HC = DEF_EXP_PERIOD_HC,
    parameter int EXP_HIGH_HC   = DEF_EXP_HIGH_HC,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
    input logic              clock_in,
    input logic              reset_n,
    clk_div_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic rise0, rise1, fall0, fall1;

    hc_sampler u_sampler (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .div_i    (mon.div_clk_in),
        .rise0_o  (rise0),
        .rise1_o  (rise1),
        .fall0_o  (fall0),
        .fall1_o  (fall1)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] hc_cnt_q, hc_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;

    logic [CNT_W-1:0] c0, c1, meas_period, meas_high, hi_next, match_inc;
    logic             err_set;

    always_comb begin
        state_d     = state_q;
        hc_cnt_d    = hc_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        match_cnt_d = match_cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_set     = 1'b0;

        // Slot h0 then slot h1; c0 is the count including h0, c1 including h1.
        c0          = rise0 ? CNT_ONE : sat_inc(hc_cnt_q);
        c1          = rise1 ? CNT_ONE : sat_inc(c0);
        meas_period = rise0 ? hc_cnt_q : c0;
        meas_high   = (rise1 && fall0) ? hc_cnt_q : hi_cnt_q;
        hi_next     = fall0 ? hc_cnt_q : (fall1 ? c0 : hi_cnt_q);
        match_inc   = sat_inc(match_cnt_q);

        unique case (state_q)
            IDLE: begin
                hc_cnt_d    = '0;
                hi_cnt_d    = '0;
                match_cnt_d = '0;
                locked_d    = 1'b0;
                state_d     = SEEK;
            end
            SEEK: begin
                hc_cnt_d = c1;
                hi_cnt_d = hi_next;
                if (rise0 || rise1) state_d = MEASURE;
            end
            MEASURE: begin
                hc_cnt_d = c1;
                hi_cnt_d = hi_next;
                if (rise0 || rise1) begin
                    valid_d  = 1'b1;
                    period_d = meas_period;
                    high_d   = meas_high;
                    if (meas_period == CNT_W'(EXP_PERIOD_HC) && meas_high == CNT_W'(EXP_HIGH_HC)) begin
                        match_cnt_d = match_inc;
                        if (match_inc == CNT_W'(LOCK_COUNT)) locked_d = 1'b1;
                    end else begin
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                        err_set     = 1'b1;
                    end
                end else if (c1 == CNT_MAX) begin
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                    err_set     = 1'b1;
                    hc_cnt_d    = '0;
                    state_d     = SEEK;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything, dropping any measurement completing this cycle.
        if (!mon.enable) begin
            state_d     = IDLE;
            hc_cnt_d    = '0;
            hi_cnt_d    = '0;
            match_cnt_d = '0;
            period_d    = period_q;
            high_d      = high_q;
            valid_d     = 1'b0;
            locked_d    = 1'b0;
            err_set     = 1'b0;
        end

        error_d = err_set ? 1'b1 : (mon.err_clear ? 1'b0 : error_q);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hc_cnt_q    <= '0;
            hi_cnt_q    <= '0;
            match_cnt_q <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hc_cnt_q    <= hc_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            match_cnt_q <= match_cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
        end
    end

    assign mon.period_hc  = period_q;
    assign mon.high_hc    = high_q;
    assign mon.meas_valid = valid_q;
    assign mon.locked     = locked_q;
    assign mon.error      = error_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: pattern-driven divided clock with hand-computed expectations.
module tb_clk_div_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned mode;
    int unsigned ph;
    int unsigned hc_idx;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    clk_div_monitor_if #(.CNT_W(8)) mon_if ();

    clk_div_monitor #(
        .CNT_W         (8),
        .EXP_PERIOD_HC (6),
        .EXP_HIGH_HC   (3),
        .LOCK_COUNT    (4)
    ) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .mon      (mon_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Half-cycle pattern: 0 = 50% div3, 1 = high 4 of 6, 2 = stuck low, 3 = 1-HC pulse.
    function automatic logic pat(input int unsigned i);
        int unsigned p;
        p = (i + ph) % 6;
        case (mode)
            0:       return p < 3;
            1:       return p < 4;
            2:       return 1'b0;
            default: return p == 0;
        endcase
    endfunction

    initial begin
        mon_if.div_clk_in = 1'b0;
        hc_idx = 0;
        forever begin
            @(clk);
            #1;
            hc_idx = hc_idx + 1;
            mon_if.div_clk_in = pat(hc_idx);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int unsigned max_cyc);
        bit seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (mon_if.meas_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, " meas_valid timeout"}, 0, 1);
    endtask

    task automatic restart(input int unsigned m, input int unsigned p);
        @(posedge clk); #1;
        mon_if.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mode = m;
        ph = p;
        mon_if.err_clear = 1'b1;
        @(posedge clk); #1;
        mon_if.err_clear = 1'b0;
        mon_if.enable = 1'b1;
    endtask

    initial begin
        int unsigned last_cyc;
        int unsigned stray;
        bit got_err;

        mode = 0;
        ph = 0;
        rst_n = 1'b1;
        mon_if.enable = 1'b0;
        mon_if.err_clear = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset period_hc", mon_if.period_hc, 0);
        check("reset high_hc", mon_if.high_hc, 0);
        check("reset meas_valid", mon_if.meas_valid, 0);
        check("reset locked", mon_if.locked, 0);
        check("reset error", mon_if.error, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: nominal divide-by-3
        restart(0, 0);
        last_cyc = 0;
        for (int unsigned k = 1; k <= 6; k++) begin
            wait_valid("t1", 20);
            check("t1 period", mon_if.period_hc, 6);
            check("t1 high", mon_if.high_hc, 3);
            check("t1 locked", mon_if.locked, (k >= 4) ? 1 : 0);
            check("t1 error", mon_if.error, 0);
            if (k > 1) check("t1 spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
            if (k == 1) begin
                @(negedge clk);
                check("t1 valid pulse width", mon_if.meas_valid, 0);
            end
        end

        // 2: high time 4 HC
        restart(1, 0);
        for (int unsigned k = 1; k <= 6; k++) begin
            wait_valid("t2", 20);
            check("t2 period", mon_if.period_hc, 6);
            check("t2 high", mon_if.high_hc, 4);
            check("t2 error", mon_if.error, 1);
            check("t2 locked", mon_if.locked, 0);
        end

        // 3: stall after lock, then recovery
        restart(0, 0);
        for (int unsigned k = 1; k <= 4; k++) wait_valid("t3 lock", 20);
        check("t3 locked before stall", mon_if.locked, 1);
        mode = 2;
        stray = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mon_if.meas_valid === 1'b1) stray++;
        end
        check("t3 no early error", mon_if.error, 0);
        check("t3 locked early", mon_if.locked, 1);
        got_err = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mon_if.meas_valid === 1'b1) stray++;
            if (mon_if.error === 1'b1) begin
                got_err = 1'b1;
                break;
            end
        end
        check("t3 timeout error", got_err, 1);
        check("t3 timeout locked", mon_if.locked, 0);
        check("t3 no meas_valid while stalled", stray, 0);
        mode = 0;
        for (int unsigned k = 1; k <= 4; k++) begin
            wait_valid("t3 relock", 20);
            check("t3 relock period", mon_if.period_hc, 6);
            check("t3 relock locked", mon_if.locked, (k == 4) ? 1 : 0);
        end
        check("t3 error sticky", mon_if.error, 1);

        // 4: 1-HC pulse in both slot phases
        for (int unsigned p = 0; p < 2; p++) begin
            restart(3, p);
            for (int unsigned k = 1; k <= 2; k++) begin
                wait_valid("t4", 20);
                check("t4 period", mon_if.period_hc, 6);
                check("t4 high", mon_if.high_hc, 1);
                check("t4 error", mon_if.error, 1);
            end
        end

        // 5: err_clear colliding with a mismatch
        restart(1, 0);
        wait_valid("t5", 20);
        @(posedge clk); #1;
        mon_if.err_clear = 1'b1;
        @(posedge clk); #1;
        check("t5 clear alone", mon_if.error, 0);
        @(posedge clk); #1;
        check("t5 collision valid", mon_if.meas_valid, 1);
        check("t5 set beats clear", mon_if.error, 1);
        @(posedge clk); #1;
        check("t5 clear next cycle", mon_if.error, 0);
        mon_if.err_clear = 1'b0;

        // 6a: enable dropped mid-period
        restart(0, 0);
        for (int unsigned k = 1; k <= 4; k++) wait_valid("t6 lock", 20);
        check("t6 locked", mon_if.locked, 1);
        @(posedge clk); #1;
        mon_if.enable = 1'b0;
        @(posedge clk); #1;
        check("t6 disable locked", mon_if.locked, 0);
        check("t6 disable period hold", mon_if.period_hc, 6);
        stray = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mon_if.meas_valid === 1'b1) stray++;
        end
        check("t6 no meas_valid idle", stray, 0);
        check("t6 error hold", mon_if.error, 0);
        @(posedge clk); #1;
        mon_if.enable = 1'b1;
        wait_valid("t6 reenable", 20);
        check("t6 reenable period", mon_if.period_hc, 6);
        check("t6 reenable high", mon_if.high_hc, 3);
        check("t6 reenable locked", mon_if.locked, 0);
        for (int unsigned k = 2; k <= 4; k++) wait_valid("t6 relock", 20);
        check("t6 relocked", mon_if.locked, 1);

        // 6b: asynchronous reset in MEASURE
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6 async rst period", mon_if.period_hc, 0);
        check("t6 async rst high", mon_if.high_hc, 0);
        check("t6 async rst locked", mon_if.locked, 0);
        check("t6 async rst valid", mon_if.meas_valid, 0);
        check("t6 async rst error", mon_if.error, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
